mmu_ctrl: RTL and testbench



---
 rtl/mmu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mmu_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_ctrl.sv
// mmu_ctrl: command sequencer for the 16x16 int8 matrix multiply unit.
// Streams weight rows into the MMU shift chain, issues activation vectors
// under a credit limit and buffers result rows in a show-ahead FIFO so the
// consumer can stall while the MMU keeps running.
module mmu_ctrl #(
   parameter int unsigned VEC_CNT_W  = 8,
   parameter int unsigned MMU_LAT    = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_load_w,
   input  logic [VEC_CNT_W-1:0] cmd_num_vec,
   input  logic                 w_valid,
   output logic                 w_ready,
   input  logic [127:0]         w_data,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [127:0]         a_data,
   output logic                 mmu_wen,
   output logic [127:0]         mmu_win,
   output logic [127:0]         mmu_ain,
   input  logic [319:0]         mmu_aout,
   output logic                 r_valid,
   input  logic                 r_ready,
   output logic [319:0]         r_data,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned RES_W = 320;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_W  = 3'd1,
      COMPUTE = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t               state;
   logic [VEC_CNT_W-1:0] num_vec_q;
   logic [VEC_CNT_W-1:0] issued;
   logic [3:0]           row_cnt;
   logic [MMU_LAT-1:0]   tok;
   logic [CNT_W-1:0]     inflight;
   logic [CNT_W-1:0]     fifo_count;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [RES_W-1:0]     mem [FIFO_DEPTH];

   logic cmd_fire;
   logic w_fire;
   logic a_fire;
   logic fifo_wr;
   logic fifo_rd;
   logic credit_ok;
   logic drain_done;

   // Handshakes and the credit check that keeps the FIFO from overflowing
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign w_fire     = w_valid && w_ready;
   assign a_fire     = a_valid && a_ready;
   assign fifo_wr    = tok[MMU_LAT-1];
   assign fifo_rd    = r_valid && r_ready;
   assign credit_ok  = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
   assign drain_done = (inflight == '0) &&
                       ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && r_ready));

   // Status and MMU drive decoded from the state register and live handshakes
   assign cmd_ready = (state == IDLE);
   assign w_ready   = (state == LOAD_W);
   assign a_ready   = (state == COMPUTE) && (issued < num_vec_q) && credit_ok;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign mmu_wen   = w_fire;
   assign mmu_win   = w_fire ? w_data : '0;
   assign mmu_ain   = a_fire ? a_data : '0;
   assign r_valid   = (fifo_count != '0);
   assign r_data    = r_valid ? mem[rd_ptr] : '0;

   // Command sequencing: weight load, vector issue, drain, completion pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         num_vec_q <= '0;
         issued    <= '0;
         row_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  num_vec_q <= cmd_num_vec;
                  issued    <= '0;
                  row_cnt   <= '0;
                  if (cmd_load_w)              state <= LOAD_W;
                  else if (cmd_num_vec != '0)  state <= COMPUTE;
                  else                         state <= DONE;
               end
            end
            LOAD_W: begin
               if (w_fire) begin
                  row_cnt <= row_cnt + 4'd1;
                  if (row_cnt == 4'd15) state <= (num_vec_q != '0) ? COMPUTE : DONE;
               end
            end
            COMPUTE: begin
               if (a_fire) begin
                  issued <= issued + VEC_CNT_W'(1);
                  if ((issued + VEC_CNT_W'(1)) == num_vec_q) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_done) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // MMU latency tracker: one token per issued vector, captured when it exits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tok      <= '0;
         inflight <= '0;
      end else begin
         tok[0] <= a_fire;
         for (int unsigned i = 1; i < MMU_LAT; i++) tok[i] <= tok[i-1];
         inflight <= inflight + CNT_W'(a_fire) - CNT_W'(fifo_wr);
      end
   end

   // Result FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
      end
   end

   // Result FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (fifo_wr) mem[wr_ptr] <= mmu_aout;
   end

`ifndef SYNTHESIS
   // The credit limit must make a write into a full FIFO impossible
   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (!(fifo_wr && (fifo_count == CNT_W'(FIFO_DEPTH))))
            else $error("mmu_ctrl: result fifo overflow");
      end
   end
`endif

endmodule

// File: tb/tb_mmu_ctrl.sv
// Directed testbench for mmu_ctrl with a behavioural 16x16 MMU (latency 1).
module tb_mmu_ctrl;

   logic         clk;
   logic         reset_n;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_load_w;
   logic [7:0]   cmd_num_vec;
   logic         w_valid;
   logic         w_ready;
   logic [127:0] w_data;
   logic         a_valid;
   logic         a_ready;
   logic [127:0] a_data;
   logic         mmu_wen;
   logic [127:0] mmu_win;
   logic [127:0] mmu_ain;
   logic [319:0] mmu_aout;
   logic         r_valid;
   logic         r_ready;
   logic [319:0] r_data;
   logic         busy;
   logic         done;

   int nchk;
   int nfail;

   mmu_ctrl #(
      .VEC_CNT_W (8),
      .MMU_LAT   (1),
      .FIFO_DEPTH(4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_load_w (cmd_load_w),
      .cmd_num_vec(cmd_num_vec),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_data     (w_data),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_data     (a_data),
      .mmu_wen    (mmu_wen),
      .mmu_win    (mmu_win),
      .mmu_ain    (mmu_ain),
      .mmu_aout   (mmu_aout),
      .r_valid    (r_valid),
      .r_ready    (r_ready),
      .r_data     (r_data),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural MMU: new row enters at row 15, so the first row lands in row 0
   logic [127:0] wrow [16];

   function automatic logic [319:0] mmu_mul(input logic [127:0] a);
      logic [319:0] r;
      int s;
      r = '0;
      for (int j = 0; j < 16; j++) begin
         s = 0;
         for (int i = 0; i < 16; i++)
            s += int'($signed(a[8*i +: 8])) * int'($signed(wrow[i][8*j +: 8]));
         r[20*j +: 20] = 20'(s);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (mmu_wen) begin
         for (int i = 0; i < 15; i++) wrow[i] <= wrow[i+1];
         wrow[15] <= mmu_win;
      end
      mmu_aout <= mmu_mul(mmu_ain);
   end

   function automatic logic [127:0] fill8(input int v);
      return {16{8'(v)}};
   endfunction

   function automatic logic [319:0] fill20(input int v);
      return {16{20'(v)}};
   endfunction

   function automatic logic [127:0] ident_row(input int k);
      logic [127:0] r;
      r = '0;
      r[8*k +: 8] = 8'd1;
      return r;
   endfunction

   function automatic logic [127:0] a_ident();
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(i - 8);
      return r;
   endfunction

   function automatic logic [319:0] exp_ident();
      logic [319:0] r;
      for (int j = 0; j < 16; j++) r[20*j +: 20] = 20'(j - 8);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_flags"},
          {cmd_ready, w_ready, a_ready, mmu_wen, r_valid, busy, done}, 7'b1000000);
      chk({tag, "_win"},   mmu_win, '0);
      chk({tag, "_ain"},   mmu_ain, '0);
      chk({tag, "_rdata"}, r_data,  '0);
   endtask

   // Identity weights, one vector with row i = i-8, result column j = j-8
   task automatic run_identity(input string tag);
      cmd_valid = 1'b1; cmd_load_w = 1'b1; cmd_num_vec = 8'd1;
      #1;
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         w_valid = 1'b1; w_data = ident_row(k);
         #1;
         if (k == 0) begin
            chk({tag, "_busy_wready"}, {busy, w_ready, a_ready}, 3'b110);
            chk({tag, "_win"}, mmu_win, ident_row(0));
         end
         if (k == 15) chk({tag, "_wen_last"}, mmu_wen, 1'b1);
         @(negedge clk);
      end
      w_valid = 1'b0; a_valid = 1'b1; a_data = a_ident();
      #1;
      chk({tag, "_aready_first"}, {a_ready, w_ready}, 2'b10);
      chk({tag, "_ain"}, mmu_ain, a_ident());
      @(negedge clk);
      a_valid = 1'b0;
      #1;
      chk({tag, "_rvalid_early"}, {r_valid, mmu_ain == '0}, 2'b01);
      @(negedge clk);
      r_ready = 1'b1;
      #1;
      chk({tag, "_rvalid"}, r_valid, 1'b1);
      chk({tag, "_rdata"}, r_data, exp_ident());
      @(negedge clk);
      r_ready = 1'b0;
      #1;
      chk({tag, "_done"}, {done, r_valid, cmd_ready}, 3'b100);
      @(negedge clk);
      #1;
      chk({tag, "_idle"}, {cmd_ready, busy, done}, 3'b100);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int rows;
      int sent;
      int recv;
      logic done_seen;

      nchk = 0; nfail = 0;
      reset_n = 1'b0;
      cmd_valid = 1'b0; cmd_load_w = 1'b0; cmd_num_vec = '0;
      w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; r_ready = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Identity weights, single vector
      run_identity("ident");

      // -128 weights loaded with w_valid toggling, then 4 vectors back to back
      cmd_valid = 1'b1; cmd_load_w = 1'b1; cmd_num_vec = 8'd4;
      @(negedge clk);
      cmd_valid = 1'b0;
      rows = 0;
      for (int c = 0; c < 40 && rows < 16; c++) begin
         w_valid = ((c % 3) != 1); w_data = fill8(-128);
         #1;
         if (c == 0) chk("tog_wen_hs", {mmu_wen, w_ready}, 2'b11);
         if (c == 1) begin
            chk("tog_wen_idle", {mmu_wen, w_ready}, 2'b01);
            chk("tog_win_idle", mmu_win, '0);
         end
         if (w_valid && w_ready) rows++;
         @(negedge clk);
      end
      for (int k = 0; k < 8; k++) begin
         w_valid = (k == 0); a_valid = (k < 4); a_data = fill8(-128); r_ready = 1'b1;
         #1;
         if (k == 0) chk("tog_wready_fall", {w_ready, mmu_wen}, 2'b00);
         if (k < 4) chk("mm_aready", {a_ready, mmu_wen}, 2'b10);
         if (k < 6) chk("mm_rvalid", r_valid, (k >= 2));
         if (k >= 2 && k < 6) chk("mm_rdata", r_data, fill20(262144));
         if (k == 6) chk("mm_done", {done, r_valid}, 2'b10);
         if (k == 7) chk("mm_idle", {cmd_ready, done}, 2'b10);
         @(negedge clk);
      end
      w_valid = 1'b0; a_valid = 1'b0; r_ready = 1'b0;

      // Backpressure: 10 vectors (all activations k+1) with r_ready held low
      cmd_valid = 1'b1; cmd_load_w = 1'b0; cmd_num_vec = 8'd10;
      @(negedge clk);
      cmd_valid = 1'b0;
      sent = 0; recv = 0; done_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         a_valid = 1'b1; a_data = fill8(sent + 1);
         #1;
         chk("bp_aready", a_ready, (c < 4));
         if (a_ready) sent++;
         if (c == 5) chk("bp_head", {r_valid, r_data}, {1'b1, fill20(-2048)});
         @(negedge clk);
      end
      r_ready = 1'b1;
      for (int c = 0; c < 60 && !done_seen; c++) begin
         a_valid = (sent < 10); a_data = fill8(sent + 1);
         #1;
         if (done) done_seen = 1'b1;
         else begin
            if (a_valid && a_ready) sent++;
            if (r_valid) begin
               chk("bp_rdata", r_data, fill20(-2048 * (recv + 1)));
               recv++;
            end
         end
         @(negedge clk);
      end
      chk("bp_recv_count", 32'(recv), 32'd10);
      chk("bp_done_seen", done_seen, 1'b1);
      a_valid = 1'b0; r_ready = 1'b0;
      #1;
      chk("bp_idle", cmd_ready, 1'b1);

      // Empty command: no load, zero vectors
      @(negedge clk);
      cmd_valid = 1'b1; cmd_load_w = 1'b0; cmd_num_vec = 8'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      chk("empty_done", {done, busy, w_ready, a_ready, cmd_ready}, 5'b11000);
      @(negedge clk);
      #1;
      chk("empty_idle", {cmd_ready, done, busy}, 3'b100);

      // Reset mid-COMPUTE with 2 results buffered
      @(negedge clk);
      cmd_valid = 1'b1; cmd_load_w = 1'b0; cmd_num_vec = 8'd5;
      @(negedge clk);
      cmd_valid = 1'b0; a_valid = 1'b1; a_data = fill8(1);
      @(negedge clk);
      a_data = fill8(2);
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_pre", {r_valid, busy, a_ready}, 3'b111);
      chk("mid_head", r_data, fill20(-2048));
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_reset_idle", {cmd_ready, busy, r_valid}, 3'b100);
      @(negedge clk);
      run_identity("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
